// File: rtl/wb_scoreboard.sv
`default_nettype none
// +------------------------------------------------------------------+
// | wb_scoreboard                                                    |
// | Register-hazard scoreboard: tracks in-flight writes, stalls      |
// | decode on RAW/overflow hazards, counts stalls, flags underflow.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module wb_scoreboard #(
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issueValid,
  input  logic        issueWriteEn,
  input  logic [2:0]  issueWriteReg,
  input  logic        srcAValid,
  input  logic [2:0]  srcAReg,
  input  logic        srcBValid,
  input  logic [2:0]  srcBReg,
  input  logic        wbWriteEn,
  input  logic [2:0]  wbWriteReg,
  output logic        stall,
  output logic [7:0]  busy,
  output logic [15:0] stallCount,
  output logic        sbError
);

  localparam logic [CNT_W-1:0] c_cnt_zero = '0;
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_max  = '1;
  localparam logic             c_bypass   = (WB_BYPASS != 0);

  logic [7:0][CNT_W-1:0] pending_q, pending_d;
  logic [15:0]           stallCount_q, stallCount_d;
  logic                  sbError_q, sbError_d;

  logic w_rdy_a, w_rdy_b, w_haz_a, w_haz_b, w_haz_w;
  logic w_stall, w_issue_fire;

  // A source is ready if idle, or (with bypass) its last pending write retires now.
  always_comb begin
    w_rdy_a = (pending_q[srcAReg] == c_cnt_zero) ||
              (c_bypass && wbWriteEn && (wbWriteReg == srcAReg) &&
               (pending_q[srcAReg] == c_cnt_one));
    w_rdy_b = (pending_q[srcBReg] == c_cnt_zero) ||
              (c_bypass && wbWriteEn && (wbWriteReg == srcBReg) &&
               (pending_q[srcBReg] == c_cnt_one));
    w_haz_a = srcAValid && !w_rdy_a;
    w_haz_b = srcBValid && !w_rdy_b;
    w_haz_w = issueWriteEn && (pending_q[issueWriteReg] == c_cnt_max) &&
              !(wbWriteEn && (wbWriteReg == issueWriteReg));
    w_stall      = issueValid && (w_haz_a || w_haz_b || w_haz_w);
    w_issue_fire = issueValid && !w_stall && issueWriteEn;
  end

  always_comb begin
    pending_d = pending_q;
    for (int r = 0; r < 8; r++) begin
      logic inc, dec;
      inc = w_issue_fire && (issueWriteReg == 3'(r));
      dec = wbWriteEn && (wbWriteReg == 3'(r)) && (pending_q[r] != c_cnt_zero);
      if (inc && !dec) begin
        pending_d[r] = pending_q[r] + c_cnt_one;
      end else if (dec && !inc) begin
        pending_d[r] = pending_q[r] - c_cnt_one;
      end
    end
  end

  always_comb begin
    stallCount_d = stallCount_q;
    if (w_stall && (stallCount_q != 16'hFFFF)) begin
      stallCount_d = stallCount_q + 16'd1;
    end
    sbError_d = sbError_q ||
                (wbWriteEn && (pending_q[wbWriteReg] == c_cnt_zero));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q    <= '0;
      stallCount_q <= 16'd0;
      sbError_q    <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      stallCount_q <= stallCount_d;
      sbError_q    <= sbError_d;
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_busy
    assign busy[g] = (pending_q[g] != c_cnt_zero);
  end

  assign stall      = w_stall;
  assign stallCount = stallCount_q;
  assign sbError    = sbError_q;

endmodule
`default_nettype wire

// File: doc/wb_scoreboard.md
# wb_scoreboard

Register-hazard scoreboard for the five-stage pipeline. It tracks outstanding register-file writes between decode and writeback, and stalls decode whenever a source operand has a write still in flight. It sits beside the decode stage and is cleared by the writeback stage's write port (`writeEn`/`writeReg`). It also counts stall cycles and flags scoreboard corruption.

## Interface
Parameters:
- `WB_BYPASS`, default 1: 1 means the register file forwards write data to a same-cycle read, so a register whose last pending write retires this cycle is treated as ready.
- `CNT_W`, default 2: width of each per-register pending counter. Maximum in-flight writes per register is 2^CNT_W-1.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset; clears all state immediately.
- `issueValid` in 1: decode holds a valid instruction attempting to advance this cycle.
- `issueWriteEn` in 1: that instruction writes a register.
- `issueWriteReg` in 3: destination register, already resolved (R7 for JAL/JALR).
- `srcAValid` in 1: the instruction reads source A.
- `srcAReg` in 3: source A register.
- `srcBValid` in 1: the instruction reads source B.
- `srcBReg` in 3: source B register.
- `wbWriteEn` in 1: the writeback stage writes the register file this cycle.
- `wbWriteReg` in 3: the writeback destination register.
- `stall` out 1: holds decode and fetch; the instruction does not issue.
- `busy` out 8: bit r is 1 when `pending[r]` != 0 (registered state view).
- `stallCount` out 16: saturating count of cycles with `stall`=1.
- `sbError` out 1: sticky; set on underflow (writeback to a register with no pending write).

## Operation
- State: `pending[0..7]`, each `CNT_W` bits. All 8 registers are tracked; R0 is a real register.
- Per-source hazard, with `rdyX = (pending[srcXReg]==0) | (WB_BYPASS & wbWriteEn & wbWriteReg==srcXReg & pending[srcXReg]==1)`:
  - `hazA = srcAValid & ~rdyA`
  - `hazB = srcBValid & ~rdyB`
- Overflow guard: `hazW = issueWriteEn & pending[issueWriteReg]==max & ~(wbWriteEn & wbWriteReg==issueWriteReg)`.
- `stall = issueValid & (hazA | hazB | hazW)`. This is combinational from state and current inputs.
- `issueFire = issueValid & ~stall & issueWriteEn`.
- Per-register update for register r: `inc = issueFire & issueWriteReg==r`, `dec = wbWriteEn & wbWriteReg==r & pending[r]!=0`.
  - inc & dec: no change.
  - inc only: +1.
  - dec only: -1.
  - Counters never wrap. The overflow guard prevents increment at max; the decrement is suppressed at 0.
- Underflow: `wbWriteEn` with `pending[wbWriteReg]==0` sets `sbError` (sticky until `rst`). The counter stays 0.
- `stallCount` increments by 1 on each cycle with `stall`=1 and saturates at 16'hFFFF.
- Flush: squashed decode instructions must arrive with `issueValid`=0. Instructions already issued always reach writeback with `wbWriteEn` equal to their `issueWriteEn`, including `writeEn`=0 cases. Instructions that issue with `issueWriteEn`=0 are not tracked.

## Timing
- Reset values: all `pending`=0, `busy`=8'h00, `stall`=0 (given `issueValid`=0), `stallCount`=0, `sbError`=0.
- Reset asserted mid-operation clears everything asynchronously. The first edge after deassertion sees an empty scoreboard.
- Issue and writeback take effect at the same rising edge. `busy` reflects them in the following cycle.
- `stall` has zero latency: it is valid in the same cycle as its inputs. There is no registered stall.
- Issue and retire to the same register in the same cycle: net count is unchanged, and `stall` is not raised by hazW.
- Issue that reads and writes the same register (e.g. `ADD R1,R1,R2`): the hazard is checked against the pre-issue count. The increment applies only if the instruction issues.
- Issue-to-dependent-issue spacing: the dependent instruction stalls until the producer's writeback cycle (`WB_BYPASS`=1) or until the cycle after it (`WB_BYPASS`=0).

## Test plan
- Reset/idle: assert `rst` mid-run with `pending[3]`=2 → `busy`=0, `stallCount`=0, `sbError`=0 immediately; `stall`=0.
- RAW: issue a write to R2; the next cycle issue a read of R2 → `stall`=1 until the cycle `wbWriteEn`/`wbWriteReg`=2. With `WB_BYPASS`=1 the stall drops in that cycle, with `WB_BYPASS`=0 one cycle later. `stallCount` equals the stall cycles.
- Simultaneous: `pending[5]`=1, issue a write to R5 while writeback retires R5 → `pending[5]` stays 1 and `busy[5]`=1.
- Overflow: three issues to R7 without writeback → `pending[7]`=3. A fourth write issue to R7 → `stall`=1 and the count stays 3. Retire R7 in the same cycle → the fourth issues and the count stays 3.
- Underflow: `wbWriteEn` with `wbWriteReg`=4 and `pending[4]`=0 → `sbError`=1 next cycle and remains 1. `pending[4]` stays 0.
- Saturation: hold a stall for 65540 cycles → `stallCount`=16'hFFFF and holds.
